alu_arbiter: RTL and testbench
==============================

# alu_arbiter

Shares the single 32-bit combinational `alu` between `NREQ` independent requesters, e.g. the main execute path and an address-generation or debug port. Requests arrive on per-requester valid/ready channels, are granted round-robin, and are issued to the ALU from registered operands. Results are held in a response register until the granted requester accepts them. The ALU instance sits outside this block; the arbiter drives its inputs and samples its outputs.

## Interface
- `NREQ`, default 2: number of requesters; legal range 2..4.
- `clk`  in  1  rising-edge clock.
- `reset`  in  1  asynchronous, active-high reset.
- `req_valid`  in  NREQ  requester i presents an operation.
- `req_ready`  out  NREQ  requester i's operation is accepted this cycle; one-hot or zero.
- `req_a`, `req_b`  in  NREQ×32  operands per requester, signed.
- `req_ctrl`  in  NREQ×5  ALU op code per requester (0x0 add … 0x9 srl).
- `resp_valid`  out  NREQ  result ready for requester i; one-hot or zero.
- `resp_ready`  in  NREQ  requester i consumes the result.
- `resp_result`  out  32  result of the last issued op.
- `resp_zero`  out  1  zero flag of the last issued op.
- `resp_err`  out  1  last op code was illegal (>0x9).
- `alu_a`, `alu_b`  out  32  to ALU `A`, `B`.
- `alu_ctrl`  out  5  to ALU `aluControl`.
- `alu_result`  in  32  from ALU `aluResult`.
- `alu_zero`  in  1  from ALU `zero`.

## Operation
- FSM states: IDLE, EXEC, RESP.
- IDLE
  - If any `req_valid` is set, grant the first requester at or after `rr_ptr` (cyclic order) with `req_valid`=1.
  - Assert `req_ready` for that requester only, combinationally, in the same cycle.
  - On the edge, latch a/b/ctrl and the grant index into the operand register, then go to EXEC.
- EXEC
  - Drive `alu_*` from the operand register.
  - On the edge, capture `alu_result`/`alu_zero` into the response register. If ctrl > 0x9, capture result 0, zero 1 and set err; otherwise err 0.
  - Set `rr_ptr` = grant+1 mod NREQ, then go to RESP.
- RESP
  - Assert `resp_valid[grant]` and hold `resp_result`/`resp_zero`/`resp_err` stable.
  - When `resp_ready[grant]` is set, go to IDLE. `resp_ready` of other requesters is ignored.
- `alu_*` outputs are driven 0 outside EXEC, so the ALU never sees X from idle requesters.
- `req_ready` is 0 in EXEC and RESP. A requester must hold its valid and operands until ready.
- Ops are never reordered. One op is in flight at most.

## Timing
- Reset values:
  - state IDLE, `rr_ptr`=0.
  - `req_ready`=0 except the combinational grant in IDLE.
  - `resp_valid`=0, `resp_result`=0, `resp_zero`=0, `resp_err`=0, `alu_*`=0.
- Accept at edge t. EXEC is cycle t+1. `resp_valid` rises in cycle t+2.
- With `resp_ready` held high, the next accept can happen in cycle t+3, giving 3 cycles per op.
- Back-to-back requests from different requesters alternate strictly under round-robin.
- A single persistent requester is regranted every 3 cycles.
- Simultaneous valid on all ports: the grant goes to `rr_ptr`'s port, or to the next valid port after it.
- `rr_ptr` wraps NREQ-1 → 0.
- `req_valid` dropping in IDLE before an edge has no effect. The grant is purely combinational from the current valids.
- Reset mid-operation (EXEC or RESP): the in-flight op is discarded with no response, and all outputs return to reset values immediately.

## Structure
- Shared package `alu_pkg` holds:
  - the enum of ALU op codes (ADD=0 … SRL=9);
  - `ALU_OP_MAX` = 9;
  - the FSM state typedef.
- The `alu` module should switch to importing the same op-code enum.
- Sub-module `rr_arbiter` (parameter NREQ) maps valid vector + `rr_ptr` → one-hot grant plus encoded index. It is purely combinational and reusable.
- The top file holds the FSM, the operand and response registers, and the pointer update.

## Test plan
- Single op: req0 add a=5, b=-7 → `req_ready[0]` in the same cycle; `resp_valid[0]` 2 cycles later; result -2 (0xFFFFFFFE), zero 0, err 0.
- Both valid every cycle, `resp_ready`=1:
  - req0 sub 3-3 and req1 xor 0xF0^0x0F;
  - grant order 0,1,0,1;
  - results 0 (zero=1) and 0xFF alternately, each 3 cycles apart.
- Backpressure: req1 sra 0x80000000 by 4 with `resp_ready` low for 5 cycles → result 0xF8000000 held stable; no new grant until ready; `resp_ready[0]` is ignored.
- Illegal op: ctrl 0x1F → result 0, zero 1, err 1. The next legal op clears err.
- Reset asserted in EXEC → `resp_valid` never rises, state IDLE, `rr_ptr`=0. The next request is served normally.
- NREQ=4, only req3 and req1 valid, `rr_ptr`=2 → req3 is granted first, then req1; the pointer wraps 3→0 correctly.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared ALU definitions: op codes, arbiter FSM states and register layouts.
package alu_pkg;

    typedef enum logic [4:0] {
        ADD  = 5'h0,
        SUB  = 5'h1,
        AND  = 5'h2,
        OR   = 5'h3,
        XOR  = 5'h4,
        SLT  = 5'h5,
        SLTU = 5'h6,
        SLL  = 5'h7,
        SRA  = 5'h8,
        SRL  = 5'h9
    } alu_op_e;

    localparam logic [4:0] ALU_OP_MAX = 5'h9;

    typedef enum logic [1:0] {
        IDLE,
        EXEC,
        RESP
    } state_t;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  ctrl;
    } operand_t;

    typedef struct packed {
        logic [31:0] result;
        logic        zero;
        logic        err;
    } response_t;

endpackage

// File: rtl/alu_arbiter_if.sv
// Per-requester request/response channels between requesters and alu_arbiter.
interface alu_arbiter_if #(
    parameter int unsigned NREQ = 2
);
    logic [NREQ-1:0]       req_valid;
    logic [NREQ-1:0]       req_ready;
    logic [NREQ-1:0][31:0] req_a;
    logic [NREQ-1:0][31:0] req_b;
    logic [NREQ-1:0][4:0]  req_ctrl;
    logic [NREQ-1:0]       resp_valid;
    logic [NREQ-1:0]       resp_ready;
    logic [31:0]           resp_result;
    logic                  resp_zero;
    logic                  resp_err;

    modport master (
        output req_valid, req_a, req_b, req_ctrl, resp_ready,
        input  req_ready, resp_valid, resp_result, resp_zero, resp_err
    );

    modport slave (
        input  req_valid, req_a, req_b, req_ctrl, resp_ready,
        output req_ready, resp_valid, resp_result, resp_zero, resp_err
    );
endinterface

// File: rtl/alu.sv
// 32-bit combinational ALU; op codes above SRL produce zero.
module alu
    import alu_pkg::*;
(
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic [4:0]  aluControl,
    output logic [31:0] aluResult,
    output logic        zero
);
    always_comb begin
        aluResult = '0;
        case (aluControl)
            ADD:     aluResult = A + B;
            SUB:     aluResult = A - B;
            AND:     aluResult = A & B;
            OR:      aluResult = A | B;
            XOR:     aluResult = A ^ B;
            SLT:     aluResult = {31'b0, $signed(A) < $signed(B)};
            SLTU:    aluResult = {31'b0, A < B};
            SLL:     aluResult = A << B[4:0];
            SRA:     aluResult = $signed(A) >>> B[4:0];
            SRL:     aluResult = A >> B[4:0];
            default: aluResult = '0;
        endcase
        zero = (aluResult == 32'd0);
    end
endmodule

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first valid requester at or after ptr, cyclically.
module rr_arbiter #(
    parameter int unsigned NREQ = 2
) (
    input  logic [NREQ-1:0]         valid,
    input  logic [$clog2(NREQ)-1:0] ptr,
    output logic [NREQ-1:0]         grant,
    output logic [$clog2(NREQ)-1:0] idx,
    output logic                    any
);
    localparam int unsigned IDXW = $clog2(NREQ);

    int unsigned cand;

    always_comb begin
        grant = '0;
        idx   = '0;
        any   = 1'b0;
        cand  = 0;
        for (int unsigned off = 0; off < NREQ; off++) begin
            cand = {{(32 - IDXW){1'b0}}, ptr} + off;
            if (cand >= NREQ) begin
                cand = cand - NREQ;
            end
            if (!any && valid[cand]) begin
                any         = 1'b1;
                grant[cand] = 1'b1;
                idx         = cand[IDXW-1:0];
            end
        end
    end
endmodule

// File: rtl/alu_arbiter.sv
// Shares one combinational ALU between NREQ requesters: round-robin grant,
// registered operands, and a response register held until the winner accepts.
module alu_arbiter
    import alu_pkg::*;
#(
    parameter int unsigned NREQ = 2
) (
    input  logic         clk,
    input  logic         reset,
    alu_arbiter_if.slave bus,
    output logic [31:0]  alu_a,
    output logic [31:0]  alu_b,
    output logic [4:0]   alu_ctrl,
    input  logic [31:0]  alu_result,
    input  logic         alu_zero
);
    localparam int unsigned IDXW = $clog2(NREQ);

    state_t          state_q, state_d;
    logic [IDXW-1:0] rr_ptr_q, rr_ptr_d;
    logic [IDXW-1:0] grant_q;
    operand_t        op_q;
    response_t       resp_q, resp_d;
    logic            load_op;

    logic [NREQ-1:0] arb_grant;
    logic [IDXW-1:0] arb_idx;
    logic            arb_any;

    rr_arbiter #(
        .NREQ (NREQ)
    ) u_rr_arbiter (
        .valid (bus.req_valid),
        .ptr   (rr_ptr_q),
        .grant (arb_grant),
        .idx   (arb_idx),
        .any   (arb_any)
    );

    always_comb begin
        state_d        = state_q;
        rr_ptr_d       = rr_ptr_q;
        resp_d         = resp_q;
        load_op        = 1'b0;
        bus.req_ready  = '0;
        bus.resp_valid = '0;
        alu_a          = '0;
        alu_b          = '0;
        alu_ctrl       = '0;
        case (state_q)
            IDLE: begin
                if (arb_any) begin
                    bus.req_ready = arb_grant;
                    load_op       = 1'b1;
                    state_d       = EXEC;
                end
            end
            EXEC: begin
                alu_a    = op_q.a;
                alu_b    = op_q.b;
                alu_ctrl = op_q.ctrl;
                // Illegal op codes never trust the ALU output.
                if (op_q.ctrl > ALU_OP_MAX) begin
                    resp_d = '{result: '0, zero: 1'b1, err: 1'b1};
                end else begin
                    resp_d = '{result: alu_result, zero: alu_zero, err: 1'b0};
                end
                rr_ptr_d = (grant_q == IDXW'(NREQ - 1)) ? '0 : grant_q + 1'b1;
                state_d  = RESP;
            end
            RESP: begin
                bus.resp_valid[grant_q] = 1'b1;
                if (bus.resp_ready[grant_q]) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            rr_ptr_q <= '0;
            grant_q  <= '0;
            op_q     <= '0;
            resp_q   <= '0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            resp_q   <= resp_d;
            if (load_op) begin
                grant_q <= arb_idx;
                op_q    <= '{a: bus.req_a[arb_idx], b: bus.req_b[arb_idx],
                             ctrl: bus.req_ctrl[arb_idx]};
            end
        end
    end

    assign bus.resp_result = resp_q.result;
    assign bus.resp_zero   = resp_q.zero;
    assign bus.resp_err    = resp_q.err;
endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter with two and four requesters.
module tb_alu_arbiter;
    import alu_pkg::*;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   n_checks = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    alu_arbiter_if #(.NREQ(2)) bus2 ();
    alu_arbiter_if #(.NREQ(4)) bus4 ();

    logic [31:0] alu2_a, alu2_b, alu2_result, alu4_a, alu4_b, alu4_result;
    logic [4:0]  alu2_ctrl, alu4_ctrl;
    logic        alu2_zero, alu4_zero;

    alu_arbiter #(.NREQ(2)) u_dut2 (
        .clk        (clk),
        .reset      (reset),
        .bus        (bus2),
        .alu_a      (alu2_a),
        .alu_b      (alu2_b),
        .alu_ctrl   (alu2_ctrl),
        .alu_result (alu2_result),
        .alu_zero   (alu2_zero)
    );

    alu u_alu2 (
        .A          (alu2_a),
        .B          (alu2_b),
        .aluControl (alu2_ctrl),
        .aluResult  (alu2_result),
        .zero       (alu2_zero)
    );

    alu_arbiter #(.NREQ(4)) u_dut4 (
        .clk        (clk),
        .reset      (reset),
        .bus        (bus4),
        .alu_a      (alu4_a),
        .alu_b      (alu4_b),
        .alu_ctrl   (alu4_ctrl),
        .alu_result (alu4_result),
        .alu_zero   (alu4_zero)
    );

    alu u_alu4 (
        .A          (alu4_a),
        .B          (alu4_b),
        .aluControl (alu4_ctrl),
        .aluResult  (alu4_result),
        .zero       (alu4_zero)
    );

    task automatic test_reset();
        @(negedge clk);
        n_checks++; if (bus2.req_ready !== 2'b00) begin n_fail++;
            $display("FAIL reset_req_ready: got %b want 00", bus2.req_ready); end
        n_checks++; if (bus2.resp_valid !== 2'b00) begin n_fail++;
            $display("FAIL reset_resp_valid: got %b want 00", bus2.resp_valid); end
        n_checks++; if ({bus2.resp_result, bus2.resp_zero, bus2.resp_err} !== 34'd0) begin
            n_fail++; $display("FAIL reset_resp_regs: got %h/%b/%b want 0/0/0",
                               bus2.resp_result, bus2.resp_zero, bus2.resp_err); end
        n_checks++; if ({alu2_a, alu2_b, alu2_ctrl} !== 69'd0) begin n_fail++;
            $display("FAIL reset_alu_outs: got %h %h %h want 0", alu2_a, alu2_b, alu2_ctrl); end
        n_checks++; if (bus4.resp_valid !== 4'b0000) begin n_fail++;
            $display("FAIL reset_resp_valid4: got %b want 0000", bus4.resp_valid); end
        reset = 1'b0;
        @(negedge clk);
        n_checks++; if (bus2.resp_valid !== 2'b00) begin n_fail++;
            $display("FAIL reset_idle_valid: got %b want 00", bus2.resp_valid); end
    endtask

    task automatic test_back_to_back();
        logic [1:0]  exp_g;
        logic [31:0] exp_r;
        @(posedge clk); #1;
        bus2.req_a[0] = 32'd3;    bus2.req_b[0] = 32'd3;    bus2.req_ctrl[0] = SUB;
        bus2.req_a[1] = 32'hF0;   bus2.req_b[1] = 32'h0F;   bus2.req_ctrl[1] = XOR;
        bus2.req_valid = 2'b11;
        bus2.resp_ready = 2'b11;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            exp_g = ((k / 3) % 2 == 0) ? 2'b01 : 2'b10;
            exp_r = ((k / 3) % 2 == 0) ? 32'h0 : 32'hFF;
            if (k % 3 == 0) begin
                n_checks++; if (bus2.req_ready !== exp_g) begin n_fail++;
                    $display("FAIL b2b_grant k=%0d: got %b want %b", k, bus2.req_ready, exp_g); end
            end else if (k % 3 == 1) begin
                n_checks++; if ({bus2.req_ready, bus2.resp_valid} !== 4'b0000) begin n_fail++;
                    $display("FAIL b2b_exec k=%0d: got %b/%b want 00/00", k,
                             bus2.req_ready, bus2.resp_valid); end
            end else begin
                n_checks++; if (bus2.resp_valid !== exp_g) begin n_fail++;
                    $display("FAIL b2b_resp_valid k=%0d: got %b want %b", k,
                             bus2.resp_valid, exp_g); end
                n_checks++; if ({bus2.resp_result, bus2.resp_zero} !== {exp_r, exp_r == 0})
                begin n_fail++; $display("FAIL b2b_result k=%0d: got %h z=%b want %h z=%b", k,
                    bus2.resp_result, bus2.resp_zero, exp_r, exp_r == 0); end
            end
        end
        @(posedge clk); #1;
        bus2.req_valid = 2'b00;
        bus2.resp_ready = 2'b00;
    endtask

    task automatic test_single();
        @(posedge clk); #1;
        bus2.req_a[0] = 32'd5; bus2.req_b[0] = 32'hFFFF_FFF9; bus2.req_ctrl[0] = ADD;
        bus2.req_valid = 2'b01;
        #1;
        n_checks++; if (bus2.req_ready !== 2'b01) begin n_fail++;
            $display("FAIL single_ready: got %b want 01", bus2.req_ready); end
        @(posedge clk); #1;
        bus2.req_valid = 2'b00;
        @(negedge clk);
        n_checks++; if ({alu2_a, alu2_b, alu2_ctrl} !== {32'd5, 32'hFFFF_FFF9, 5'h0}) begin
            n_fail++; $display("FAIL single_alu_drive: got %h %h %h want 5 fffffff9 0",
                               alu2_a, alu2_b, alu2_ctrl); end
        n_checks++; if (bus2.resp_valid !== 2'b00) begin n_fail++;
            $display("FAIL single_early_valid: got %b want 00", bus2.resp_valid); end
        @(negedge clk);
        n_checks++; if (bus2.resp_valid !== 2'b01) begin n_fail++;
            $display("FAIL single_resp_valid: got %b want 01", bus2.resp_valid); end
        n_checks++; if ({bus2.resp_result, bus2.resp_zero, bus2.resp_err}
                        !== {32'hFFFF_FFFE, 1'b0, 1'b0}) begin n_fail++;
            $display("FAIL single_result: got %h/%b/%b want fffffffe/0/0",
                     bus2.resp_result, bus2.resp_zero, bus2.resp_err); end
        bus2.resp_ready = 2'b01;
        @(posedge clk); #1;
        bus2.resp_ready = 2'b00;
        @(negedge clk);
        n_checks++; if (bus2.resp_valid !== 2'b00) begin n_fail++;
            $display("FAIL single_resp_drop: got %b want 00", bus2.resp_valid); end
    endtask

    task automatic test_reset_mid();
        @(posedge clk); #1;
        bus2.req_a[1] = 32'd9; bus2.req_b[1] = 32'd9; bus2.req_ctrl[1] = ADD;
        bus2.req_valid = 2'b10;
        @(posedge clk); #1;
        bus2.req_valid = 2'b00;
        @(negedge clk);
        n_checks++; if (alu2_a !== 32'd9) begin n_fail++;
            $display("FAIL rstmid_in_exec: got %h want 9", alu2_a); end
        reset = 1'b1;
        #1;
        n_checks++; if ({alu2_a, alu2_b, alu2_ctrl} !== 69'd0) begin n_fail++;
            $display("FAIL rstmid_alu_zeroed: got %h %h %h want 0", alu2_a, alu2_b, alu2_ctrl); end
        n_checks++; if ({bus2.resp_valid, bus2.resp_result} !== 34'd0) begin n_fail++;
            $display("FAIL rstmid_resp_cleared: got %b %h want 00 0",
                     bus2.resp_valid, bus2.resp_result); end
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            n_checks++; if (bus2.resp_valid !== 2'b00) begin n_fail++;
                $display("FAIL rstmid_no_resp i=%0d: got %b want 00", i, bus2.resp_valid); end
        end
        @(posedge clk); #1;
        bus2.req_a[0] = 32'd10; bus2.req_b[0] = 32'd3; bus2.req_ctrl[0] = SUB;
        bus2.req_a[1] = 32'd1;  bus2.req_b[1] = 32'd1; bus2.req_ctrl[1] = ADD;
        bus2.req_valid = 2'b11;
        @(negedge clk);
        n_checks++; if (bus2.req_ready !== 2'b01) begin n_fail++;
            $display("FAIL rstmid_ptr_zero: got %b want 01", bus2.req_ready); end
        @(posedge clk); #1;
        bus2.req_valid = 2'b00;
        @(negedge clk);
        @(negedge clk);
        n_checks++; if ({bus2.resp_valid, bus2.resp_result} !== {2'b01, 32'd7}) begin n_fail++;
            $display("FAIL rstmid_next_op: got %b %h want 01 7", bus2.resp_valid,
                     bus2.resp_result); end
        bus2.resp_ready = 2'b01;
        @(posedge clk); #1;
        bus2.resp_ready = 2'b00;
    endtask

    task automatic test_backpressure();
        @(posedge clk); #1;
        bus2.req_a[1] = 32'h8000_0000; bus2.req_b[1] = 32'd4; bus2.req_ctrl[1] = SRA;
        bus2.req_valid = 2'b10;
        bus2.resp_ready = 2'b01;
        @(negedge clk);
        n_checks++; if (bus2.req_ready !== 2'b10) begin n_fail++;
            $display("FAIL bp_grant: got %b want 10", bus2.req_ready); end
        @(posedge clk); #1;
        bus2.req_a[0] = 32'd1; bus2.req_b[0] = 32'd1; bus2.req_ctrl[0] = ADD;
        bus2.req_valid = 2'b01;
        @(posedge clk);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            n_checks++; if ({bus2.resp_valid, bus2.resp_result} !== {2'b10, 32'hF800_0000})
            begin n_fail++; $display("FAIL bp_hold i=%0d: got %b %h want 10 f8000000", i,
                                     bus2.resp_valid, bus2.resp_result); end
            n_checks++; if (bus2.req_ready !== 2'b00) begin n_fail++;
                $display("FAIL bp_no_grant i=%0d: got %b want 00", i, bus2.req_ready); end
            if (i < 4) @(posedge clk);
        end
        bus2.resp_ready = 2'b11;
        @(posedge clk); #1;
        bus2.req_valid = 2'b00;
        bus2.resp_ready = 2'b00;
        @(negedge clk);
        n_checks++; if ({bus2.resp_valid, bus2.resp_result} !== {2'b00, 32'hF800_0000}) begin
            n_fail++; $display("FAIL bp_release: got %b %h want 00 f8000000",
                               bus2.resp_valid, bus2.resp_result); end
    endtask

    task automatic test_illegal();
        @(posedge clk); #1;
        bus2.req_a[0] = 32'd123; bus2.req_b[0] = 32'd456; bus2.req_ctrl[0] = 5'h1F;
        bus2.req_valid = 2'b01;
        @(negedge clk);
        n_checks++; if (bus2.req_ready !== 2'b01) begin n_fail++;
            $display("FAIL ill_grant: got %b want 01", bus2.req_ready); end
        @(posedge clk); #1;
        bus2.req_valid = 2'b00;
        @(negedge clk);
        n_checks++; if (alu2_ctrl !== 5'h1F) begin n_fail++;
            $display("FAIL ill_alu_ctrl: got %h want 1f", alu2_ctrl); end
        @(negedge clk);
        n_checks++; if ({bus2.resp_valid, bus2.resp_result, bus2.resp_zero, bus2.resp_err}
                        !== {2'b01, 32'd0, 1'b1, 1'b1}) begin n_fail++;
            $display("FAIL ill_resp: got %b %h z=%b e=%b want 01 0 z=1 e=1", bus2.resp_valid,
                     bus2.resp_result, bus2.resp_zero, bus2.resp_err); end
        bus2.resp_ready = 2'b01;
        @(posedge clk); #1;
        bus2.resp_ready = 2'b00;
        bus2.req_a[1] = 32'd1; bus2.req_b[1] = 32'd1; bus2.req_ctrl[1] = ADD;
        bus2.req_valid = 2'b10;
        @(negedge clk);
        n_checks++; if (bus2.req_ready !== 2'b10) begin n_fail++;
            $display("FAIL ill_next_grant: got %b want 10", bus2.req_ready); end
        @(posedge clk); #1;
        bus2.req_valid = 2'b00;
        @(negedge clk);
        @(negedge clk);
        n_checks++; if ({bus2.resp_valid, bus2.resp_result, bus2.resp_zero, bus2.resp_err}
                        !== {2'b10, 32'd2, 1'b0, 1'b0}) begin n_fail++;
            $display("FAIL ill_err_clear: got %b %h z=%b e=%b want 10 2 z=0 e=0",
                     bus2.resp_valid, bus2.resp_result, bus2.resp_zero, bus2.resp_err); end
        bus2.resp_ready = 2'b10;
        @(posedge clk); #1;
        bus2.resp_ready = 2'b00;
    endtask

    task automatic test_drop_valid();
        @(posedge clk); #1;
        bus2.req_a[1] = 32'd77; bus2.req_b[1] = 32'd1; bus2.req_ctrl[1] = ADD;
        bus2.req_valid = 2'b10;
        #2;
        n_checks++; if (bus2.req_ready !== 2'b10) begin n_fail++;
            $display("FAIL drop_comb_grant: got %b want 10", bus2.req_ready); end
        bus2.req_valid = 2'b00;
        @(negedge clk);
        n_checks++; if (bus2.req_ready !== 2'b00) begin n_fail++;
            $display("FAIL drop_ready_gone: got %b want 00", bus2.req_ready); end
        @(negedge clk);
        n_checks++; if ({alu2_a, bus2.resp_valid} !== 34'd0) begin n_fail++;
            $display("FAIL drop_no_issue: got %h %b want 0 00", alu2_a, bus2.resp_valid); end
    endtask

    task automatic test_nreq4();
        logic [3:0]  exp_g [2];
        logic [31:0] exp_r [2];
        exp_g[0] = 4'b1000; exp_r[0] = 32'hA5;
        exp_g[1] = 4'b0010; exp_r[1] = 32'h10;
        @(posedge clk); #1;
        bus4.req_a[1] = 32'd1; bus4.req_b[1] = 32'd2; bus4.req_ctrl[1] = ADD;
        bus4.req_valid = 4'b0010;
        bus4.resp_ready = 4'b1111;
        @(negedge clk);
        n_checks++; if (bus4.req_ready !== 4'b0010) begin n_fail++;
            $display("FAIL n4_first_grant: got %b want 0010", bus4.req_ready); end
        @(posedge clk); #1;
        bus4.req_a[3] = 32'hA0; bus4.req_b[3] = 32'h05; bus4.req_ctrl[3] = OR;
        bus4.req_a[1] = 32'd1;  bus4.req_b[1] = 32'd4;  bus4.req_ctrl[1] = SLL;
        bus4.req_valid = 4'b1010;
        @(negedge clk);
        @(negedge clk);
        n_checks++; if ({bus4.resp_valid, bus4.resp_result} !== {4'b0010, 32'd3}) begin
            n_fail++; $display("FAIL n4_first_resp: got %b %h want 0010 3",
                               bus4.resp_valid, bus4.resp_result); end
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (k % 3 == 0) begin
                n_checks++; if (bus4.req_ready !== exp_g[k / 3]) begin n_fail++;
                    $display("FAIL n4_grant k=%0d: got %b want %b", k, bus4.req_ready,
                             exp_g[k / 3]); end
            end else if (k % 3 == 2) begin
                n_checks++; if ({bus4.resp_valid, bus4.resp_result}
                                !== {exp_g[k / 3], exp_r[k / 3]}) begin n_fail++;
                    $display("FAIL n4_resp k=%0d: got %b %h want %b %h", k, bus4.resp_valid,
                             bus4.resp_result, exp_g[k / 3], exp_r[k / 3]); end
            end
        end
        @(posedge clk); #1;
        bus4.req_valid = 4'b0000;
        bus4.resp_ready = 4'b0000;
    endtask

    initial begin
        bus2.req_valid = '0; bus2.req_a = '0; bus2.req_b = '0; bus2.req_ctrl = '0;
        bus2.resp_ready = '0;
        bus4.req_valid = '0; bus4.req_a = '0; bus4.req_b = '0; bus4.req_ctrl = '0;
        bus4.resp_ready = '0;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        test_reset();
        test_back_to_back();
        test_single();
        test_reset_mid();
        test_backpressure();
        test_illegal();
        test_drop_valid();
        test_nreq4();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end
endmodule
